// File: rtl/fir_pkg.sv
// fir_pkg: shared defaults, width/latency derivation and clog2 for the FIR slice
package fir_pkg;

    localparam int DEF_DATA_WIDTH = 13;
    localparam int DEF_COEF_WIDTH = 13;
    localparam int DEF_TAPS       = 9;
    localparam int DEF_FRAC_BITS  = 12;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

    function automatic int lat(input int taps);
        return 2 + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// fir_adder_tree: registered binary adder tree, inputs zero-padded to a power of two
module fir_adder_tree
    import fir_pkg::*;
#(
    parameter int N     = DEF_TAPS,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    vin,
    input  logic signed [WIDTH-1:0] din [N],
    output logic                    vout,
    output logic signed [WIDTH-1:0] sum
);

    localparam int L = clog2(N);
    localparam int P = 1 << L;

    logic signed [WIDTH-1:0] src [L][P];
    logic signed [WIDTH-1:0] lvl [L][P];
    logic [L-1:0]            vld;

    // operands of each level: padded inputs for the first, previous level's sums after that
    always_comb begin
        for (int l = 0; l < L; l++)
            for (int i = 0; i < P; i++)
                src[l][i] = (l == 0) ? ((i < N) ? din[(i < N) ? i : 0] : '0) : lvl[(l == 0) ? 0 : l - 1][i];
    end

    // one pipeline register per level; unused upper slots stay zero
    always_ff @(posedge clk) begin
        for (int l = 0; l < L; l++)
            for (int i = 0; i < P; i++)
                lvl[l][i] <= rst ? '0 : (i < (P >> (l + 1))) ? src[l][(2 * i) & (P - 1)] + src[l][(2 * i + 1) & (P - 1)] : '0;
        vld <= rst ? '0 : L'({vld, vin});
    end

    assign vout = vld[L-1];
    assign sum  = lvl[L-1][0];

endmodule

// File: rtl/fir_pipe_mc.sv
// fir_pipe_mc: pipelined direct-form FIR with writable coefficients, rounding and saturation
module fir_pipe_mc
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         VIN,
    input  logic signed [DATA_WIDTH-1:0] DIN,
    input  logic                         COEF_WE,
    input  logic [clog2(TAPS)-1:0]       COEF_ADDR,
    input  logic signed [COEF_WIDTH-1:0] COEF_DATA,
    output logic signed [DATA_WIDTH-1:0] DOUT,
    output logic                         VOUT,
    output logic                         SAT
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);
    localparam int PW        = DATA_WIDTH + COEF_WIDTH;
    localparam logic signed [ACC_WIDTH:0]    HALF = (ACC_WIDTH + 1)'((2 ** FRAC_BITS) / 2);
    localparam logic signed [DATA_WIDTH-1:0] DMAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] DMIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0]    XMAX = (ACC_WIDTH + 1)'(DMAX);
    localparam logic signed [ACC_WIDTH:0]    XMIN = (ACC_WIDTH + 1)'(DMIN);

    logic signed [COEF_WIDTH-1:0] h    [TAPS];
    logic signed [DATA_WIDTH-1:0] hist [TAPS-1];
    logic signed [DATA_WIDTH-1:0] smp  [TAPS];
    logic signed [ACC_WIDTH-1:0]  prod [TAPS];
    logic                         p_vld;
    logic                         s_vld;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH:0]    scaled;

    // the window seen by a sample arriving now: DIN at tap 0, history behind it
    always_comb begin
        for (int k = 0; k < TAPS; k++)
            smp[k] = (k == 0) ? DIN : hist[(k == 0) ? 0 : k - 1];
    end

    // coefficient bank; out-of-range addresses are dropped
    always_ff @(posedge CLK) begin
        if (RST)
            for (int k = 0; k < TAPS; k++) h[k] <= '0;
        else if (COEF_WE && int'(COEF_ADDR) < TAPS)
            h[COEF_ADDR] <= COEF_DATA;
    end

    // delay line advances only on accepted samples
    always_ff @(posedge CLK) begin
        for (int k = 0; k < TAPS - 1; k++)
            hist[k] <= RST ? '0 : VIN ? smp[k] : hist[k];
    end

    // product stage captures the coefficients in force before any same-cycle write
    always_ff @(posedge CLK) begin
        p_vld <= !RST && VIN;
        for (int k = 0; k < TAPS; k++)
            prod[k] <= RST ? '0 : ACC_WIDTH'(PW'(smp[k]) * PW'(h[k]));
    end

    fir_adder_tree #(
        .N     (TAPS),
        .WIDTH (ACC_WIDTH)
    ) u_tree (
        .clk  (CLK),
        .rst  (RST),
        .vin  (p_vld),
        .din  (prod),
        .vout (s_vld),
        .sum  (acc)
    );

    // round half up, one guard bit so the rounding add cannot wrap
    always_comb scaled = ((ACC_WIDTH + 1)'(acc) + HALF) >>> FRAC_BITS;

    // output register clips to the sample range and holds between valid samples
    always_ff @(posedge CLK) begin
        if (RST) begin
            DOUT <= '0;
            SAT  <= 1'b0;
            VOUT <= 1'b0;
        end else begin
            VOUT <= s_vld;
            if (s_vld) begin
                DOUT <= (scaled > XMAX) ? DMAX : (scaled < XMIN) ? DMIN : scaled[DATA_WIDTH-1:0];
                SAT  <= (scaled > XMAX) || (scaled < XMIN);
            end
        end
    end

endmodule

// File: tb/tb_fir_pipe_mc.sv
// tb_fir_pipe_mc: scoreboard bench driving an integer-coefficient and a fractional-coefficient FIR
module tb_fir_pipe_mc;

    localparam int T   = 9;
    localparam int LAT = 6;

    typedef struct {
        int d;
        bit s;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vin = 1'b0;
    logic coef_we = 1'b0;
    logic signed [12:0] din = '0;
    logic signed [12:0] coef_data = '0;
    logic [3:0] coef_addr = '0;

    logic signed [12:0] dout0, dout12;
    logic vout0, vout12, sat0, sat12;

    exp_t q0[$];
    exp_t q12[$];
    int h_m [T];
    int x_m [T];
    int cyc = 0;
    int ntest = 0;
    int nfail = 0;
    int last_d [2] = '{0, 0};
    bit last_s [2] = '{0, 0};
    bit mon_en = 1'b0;

    fir_pipe_mc #(.FRAC_BITS(0)) u0 (
        .CLK(clk), .RST(rst), .VIN(vin), .DIN(din),
        .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .DOUT(dout0), .VOUT(vout0), .SAT(sat0)
    );

    fir_pipe_mc u12 (
        .CLK(clk), .RST(rst), .VIN(vin), .DIN(din),
        .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data),
        .DOUT(dout12), .VOUT(vout12), .SAT(sat12)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic exp_t mk(input longint acc, input int frac);
        exp_t e;
        longint y;
        y = (frac > 0) ? ((acc + (longint'(1) << (frac - 1))) >>> frac) : acc;
        e.s = (y > 4095) || (y < -4096);
        e.d = (y > 4095) ? 4095 : (y < -4096) ? -4096 : int'(y);
        e.due = cyc + LAT;
        return e;
    endfunction

    task automatic step(input bit r, input bit v, input int d, input bit we, input int a, input int cd);
        longint acc;
        @(posedge clk);
        #2;
        rst = r;
        vin = v;
        din = 13'(d);
        coef_we = we;
        coef_addr = 4'(a);
        coef_data = 13'(cd);
        if (r) begin
            for (int k = 0; k < T; k++) begin
                h_m[k] = 0;
                x_m[k] = 0;
            end
        end else begin
            if (v) begin
                for (int k = T - 1; k > 0; k--) x_m[k] = x_m[k-1];
                x_m[0] = d;
                acc = 0;
                for (int k = 0; k < T; k++) acc += longint'(h_m[k]) * x_m[k];
                q0.push_back(mk(acc, 0));
                q12.push_back(mk(acc, 12));
            end
            if (we && a < T) h_m[a] = cd;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input int id, input logic v, input logic signed [12:0] d, input logic s);
        exp_t e;
        int n;
        n = (id == 0) ? q0.size() : q12.size();
        ntest++;
        if (v === 1'b1) begin
            if (n == 0) begin
                nfail++;
                $display("FAIL vout_unexpected dut%0d cyc=%0d got d=%0d sat=%0b want no VOUT", id, cyc, d, s);
            end else begin
                if (id == 0) e = q0.pop_front();
                else e = q12.pop_front();
                if (d !== 13'(e.d) || s !== e.s || cyc != e.due) begin
                    nfail++;
                    $display("FAIL sample dut%0d cyc=%0d got d=%0d sat=%0b want d=%0d sat=%0b at cyc=%0d",
                             id, cyc, d, s, e.d, e.s, e.due);
                end
                last_d[id] = e.d;
                last_s[id] = e.s;
            end
        end else if (v !== 1'b0 || d !== 13'(last_d[id]) || s !== last_s[id]) begin
            nfail++;
            $display("FAIL hold dut%0d cyc=%0d got v=%0b d=%0d sat=%0b want v=0 d=%0d sat=%0b",
                     id, cyc, v, d, s, last_d[id], last_s[id]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk(0, vout0, dout0, sat0);
            chk(1, vout12, dout12, sat12);
            if (rst) begin
                q0.delete();
                q12.delete();
                last_d = '{0, 0};
                last_s = '{0, 0};
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        idle(2);
        for (int k = 0; k < T; k++) step(0, 0, 0, 1, k, k + 1);
        step(0, 1, 1, 0, 0, 0);
        repeat (8) step(0, 1, 0, 0, 0, 0);
        idle(8);
        for (int i = 0; i < T; i++) begin
            step(0, 1, (i == 0) ? 1 : 0, 0, 0, 0);
            idle(2);
        end
        idle(8);
        for (int k = 0; k < T; k++) step(0, 0, 0, 1, k, 4095);
        repeat (9) step(0, 1, 4095, 0, 0, 0);
        repeat (9) step(0, 1, -4096, 0, 0, 0);
        idle(8);
        for (int k = 0; k < T; k++) step(0, 0, 0, 1, k, (k == 0) ? 2048 : 0);
        step(0, 1, 3, 0, 0, 0);
        step(0, 1, -3, 0, 0, 0);
        idle(8);
        step(0, 0, 0, 1, 0, 1);
        step(0, 1, 1, 1, 0, 5);
        repeat (8) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 9, 100);
        step(0, 1, 1, 0, 0, 0);
        repeat (8) step(0, 1, 0, 0, 0, 0);
        idle(8);
        repeat (300)
            step(0, $urandom_range(0, 2) != 0, int'($urandom_range(0, 8191)) - 4096,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 8191)) - 4096);
        idle(8);
        for (int k = 0; k < T; k++) step(0, 0, 0, 1, k, k + 1);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 5, 1, 0, 7);
        step(1, 1, 5, 1, 3, 7);
        repeat (12) step(0, 1, int'($urandom_range(0, 8191)) - 4096, 0, 0, 0);
        idle(10);
        ntest++;
        if (q0.size() + q12.size() != 0) begin
            nfail++;
            $display("FAIL pending got %0d outstanding samples want 0", q0.size() + q12.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/fir_pipe_mc.md
FIR_PIPE_MC -- requirements
Module: fir_pipe_mc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 13, meaning signed sample width of DIN and DOUT.
REQ-002 The block SHALL have parameter COEF_WIDTH, default 13, meaning signed coefficient width.
REQ-003 The block SHALL have parameter TAPS, default 9, meaning number of coefficients (legal range 2..64).
REQ-004 The block SHALL have parameter FRAC_BITS, default 12, meaning fractional bits of coefficients (legal range 0..COEF_WIDTH-1).
REQ-005 The block SHALL have port CLK, input, 1 bit, meaning the single clock; all logic rising-edge.
REQ-006 The block SHALL have port RST, input, 1 bit, meaning reset, synchronous and active-high.
REQ-007 The block SHALL have port VIN, input, 1 bit, meaning DIN valid this cycle.
REQ-008 The block SHALL have port DIN, input, DATA_WIDTH bits, meaning signed input sample.
REQ-009 The block SHALL have port COEF_WE, input, 1 bit, meaning coefficient write strobe.
REQ-010 The block SHALL have port COEF_ADDR, input, clog2(TAPS) bits, meaning coefficient index.
REQ-011 The block SHALL have port COEF_DATA, input, COEF_WIDTH bits, meaning signed coefficient value.
REQ-012 The block SHALL have port DOUT, output, DATA_WIDTH bits, meaning signed filtered sample.
REQ-013 The block SHALL have port VOUT, output, 1 bit, meaning DOUT valid; one-cycle pulse per accepted VIN.
REQ-014 The block SHALL have port SAT, output, 1 bit, meaning the current VOUT sample was clipped.

Function
REQ-015 Delay line SHALL shift only on VIN=1; x[0]=DIN, x[k]=previous x[k-1]; unchanged when VIN=0.
REQ-016 Output SHALL be y = sum over k=0..TAPS-1 of H[k]*x[k], where x[k] is the sample k accepted VINs earlier (earlier taps 0 after reset).
REQ-017 Accumulation SHALL be full precision: ACC_WIDTH = DATA_WIDTH+COEF_WIDTH+clog2(TAPS); no intermediate truncation.
REQ-018 Scaling SHALL be round-half-up: (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic); no rounding term when FRAC_BITS=0.
REQ-019 Saturation SHALL clip to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] and assert SAT with that VOUT; otherwise SAT=0.
REQ-020 Pipeline SHALL be: product register (1 cycle), one register per adder-tree level (clog2(TAPS) cycles), round/saturate register (1 cycle).
REQ-021 Latency SHALL be fixed, LAT = 2+clog2(TAPS) cycles from VIN edge to VOUT (6 at defaults), independent of VIN gaps.
REQ-022 VIN SHALL be accepted every cycle (no back-pressure); back-to-back VIN SHALL give back-to-back VOUT.
REQ-023 DOUT and SAT SHALL hold their last value while VOUT=0.
REQ-024 COEF_WE=1 SHALL write COEF_DATA to H[COEF_ADDR] at that edge; COEF_ADDR >= TAPS SHALL be ignored.
REQ-025 VIN and COEF_WE in the same cycle SHALL use the old coefficient for that sample; the new value applies from the next VIN.
REQ-026 In-flight samples SHALL complete with the coefficients registered at their product stage; no flush on coefficient write.

Reset
REQ-027 RST=1 SHALL clear delay line, all pipeline registers, valid pipe, DOUT=0, VOUT=0, SAT=0 at the next edge.
REQ-028 RST SHALL clear all coefficients to 0.
REQ-029 Reset mid-operation SHALL discard in-flight samples; no VOUT for any VIN accepted before or during RST.
REQ-030 VIN and COEF_WE during RST SHALL be ignored.

Structure
REQ-031 Package fir_pkg SHALL hold default parameter constants, the ACC_WIDTH/LAT derivation, and the clog2 function.
REQ-032 Registered adder tree SHALL be sub-module fir_adder_tree (parameters N, WIDTH; valid in/out; zero-padded to a power of two).

Verification
REQ-033 Impulse: FRAC_BITS=0, H[k]=k+1, DIN=1 then 8 zeros with VIN=1 -> DOUT 1,2,...,9 on consecutive VOUT, first at cycle 6.
REQ-034 Gapped VIN: same stimulus with VIN high every third cycle -> same DOUT sequence, each VOUT exactly 6 cycles after its VIN.
REQ-035 Saturation: FRAC_BITS=0, all H=4095, DIN=4095 x9 -> DOUT=4095, SAT=1; all DIN=-4096 -> DOUT=-4096, SAT=1 (products -16773120 sum negative).
REQ-036 Rounding: FRAC_BITS=12, H[0]=2048, other H=0, DIN=3 -> DOUT=2 (1.5 rounds up); DIN=-3 -> DOUT=-1.
REQ-037 Coef update: write H[0]=5 in the same cycle as VIN with DIN=1 (old H[0]=1, FRAC=0) -> that output 1; next impulse output 5; COEF_ADDR=9 write has no effect.
REQ-038 Reset mid-stream: RST at cycle 3 of an impulse run -> no VOUT afterwards, DOUT=0, SAT=0, all H=0 until rewritten.
